tile_map_arbiter: RTL and testbench
===================================

# tile_map_arbiter

Shares the single-port tile-map RAM (40×30 tiles, 8-bit tile codes) between the VGA tile-fetch path and a writer port driven by update logic such as switches or a keyboard. Display fetches always win the RAM, so the picture never tears. Writes are buffered in a small FIFO and drained only in cycles with no display fetch. An optional clear sequencer blanks the whole map. The block sits between the tile renderer and the tile-map RAM, in the 25 MHz pixel clock domain.

## Interface
- AW, 11, tile-map address width
- DW, 8, tile code width
- DEPTH, 4, write FIFO depth (power of two)
- TILES, 1200, number of map entries (valid addresses 0..TILES-1)
- CLEAR_VAL, 8'h00, code written by the clear sequencer
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-high reset
- disp_req  in  1  display fetch request this cycle
- disp_addr  in  AW  display fetch address
- disp_data  out  DW  fetched tile code (= ram_rdata)
- disp_valid  out  1  disp_data valid
- wr_valid  in  1  writer has a write
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  RAM write this cycle
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, one cycle after a read access
- clear_start  in  1  request a full-map clear (TILE_ARB_CLEAR_EN only)
- clear_busy  out  1  clear pending or in progress (TILE_ARB_CLEAR_EN only)

## Operation
- Per-cycle slot priority: display fetch > clear write > FIFO drain > idle.
- Display slot: ram_en=1, ram_we=0, ram_addr=disp_addr.
- FIFO drain slot: pop the head entry; ram_en=1, ram_we=1, ram_addr/ram_wdata = head.
- Idle: ram_en=0, ram_we=0. ram_addr and ram_wdata hold their values.
- The RAM-side outputs are a combinational mux of the current-cycle sources. disp_data is ram_rdata passed through.
- wr_ready = !rst && !full && !clear_busy. When full, no push occurs even if a pop happens in the same cycle.
- No bypass: an accepted write enters the FIFO and reaches the RAM on the first display-free cycle after acceptance.
- FIFO order is preserved.
- A display read of an address still queued in the FIFO returns the old RAM contents. This is by design.
- Push and pop in the same cycle leave fifo_level unchanged.
- Pointers wrap modulo DEPTH.
- Addresses ≥ TILES are passed to the RAM unchanged; the block does not check them.

## Timing
- Reset (async assert): FIFO empty, fifo_level=0, disp_valid=0, wr_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, clear_busy=0.
- First cycle after reset release: wr_ready=1.
- Read latency is one cycle. disp_req at cycle N gives disp_valid=1 at N+1, with disp_data = mem[disp_addr] as of the start of cycle N.
- disp_valid is a register of disp_req.
- Continuous disp_req starves writes indefinitely. The FIFO fills and wr_ready drops. Drain resumes in blanking (disp_req=0).
- Reset asserted mid-operation discards queued writes and any clear in progress. A RAM write is never issued while rst=1.

## Configuration
- Macro TILE_ARB_CLEAR_EN.
- Defined: clear_start and clear_busy ports exist.
  - States: IDLE, PEND, CLEAR.
  - clear_start in IDLE moves to PEND; clear_busy=1 from the next cycle, and wr_ready=0.
  - PEND waits for the FIFO to drain, then moves to CLEAR with the counter at 0.
  - CLEAR writes CLEAR_VAL to the counter address in each display-free cycle, then increments the counter.
  - After writing TILES-1, the sequencer returns to IDLE; clear_busy=0 on the following cycle.
  - clear_start in PEND or CLEAR is ignored.
- Undefined: both ports are absent, and the arbiter has only the display and FIFO sources.

## Test plan
- Reset, then a display read of addr 5 (mem[5]=8'h3C) → disp_valid=1 next cycle, disp_data=8'h3C, and ram_we stays 0.
- Push 3 writes with disp_req=0 → RAM writes issued in order on cycles 1, 2, 3 after the first acceptance; fifo_level returns to 0.
- Hold disp_req=1 and push 5 writes with DEPTH=4 → the 4th push fills the FIFO, wr_ready=0 for the 5th, no RAM write occurs; after disp_req drops, 4 writes drain on consecutive cycles.
- Full FIFO, disp_req=0, wr_valid=1 → one pop without a push; wr_ready=1 on the next cycle.
- Assert rst with 2 entries queued → fifo_level=0 and ram_en=0 immediately; the queued writes never reach the RAM.
- TILE_ARB_CLEAR_EN: 1 entry queued, pulse clear_start, disp_req toggling 50% → the FIFO write lands first, then exactly 1200 writes of 8'h00 to addresses 0..1199, then clear_busy=0 and wr_ready=1.

Source files
------------

// File: rtl/tile_map_arbiter.sv
// Tile-map RAM arbiter: display fetches always win the single RAM port, buffered writes drain in
// display-free cycles. Define TILE_ARB_CLEAR_EN to add the full-map clear sequencer.
module tile_map_arbiter #(
  parameter int            AW        = 11,
  parameter int            DW        = 8,
  parameter int            DEPTH     = 4,
  parameter int            TILES     = 1200,
  parameter logic [DW-1:0] CLEAR_VAL = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_req,
  input  logic [AW-1:0]              disp_addr,
  output logic [DW-1:0]              disp_data,
  output logic                       disp_valid,
  input  logic                       wr_valid,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr,
  output logic [DW-1:0]              ram_wdata,
  input  logic [DW-1:0]              ram_rdata
`ifdef TILE_ARB_CLEAR_EN
  ,
  input  logic                       clear_start,
  output logic                       clear_busy
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic          full, empty, push, pop;
  logic          busy, slot_disp, slot_clear;
  logic [AW-1:0] clr_addr;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign wr_ready   = !rst && !full && !busy;
  assign push       = wr_valid && wr_ready;
  // Every RAM source is gated by rst so no access can leak out while reset is held.
  assign slot_disp  = disp_req && !rst;
  assign pop        = !rst && !disp_req && !slot_clear && !empty;
  assign fifo_level = level;
  assign disp_data  = ram_rdata;

`ifdef TILE_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, PEND, CLEAR} clr_state_t;

  clr_state_t    state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every output of an always_comb gets a default first, otherwise the tool infers a latch.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE:  if (clear_start) state_nxt = PEND;
      PEND:  if (empty) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
             end
      CLEAR: if (!disp_req) begin
               clr_cnt_nxt = clr_cnt + 1'b1;
               if (clr_cnt == AW'(TILES - 1)) state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign slot_clear = (state == CLEAR) && !disp_req;
  assign clr_addr   = clr_cnt;
  assign clear_busy = busy;
`else
  assign busy       = 1'b0;
  assign slot_clear = 1'b0;
  assign clr_addr   = AW'(TILES - 1);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and level alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = hold_addr;
    ram_wdata = hold_wdata;
    if (slot_disp) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (slot_clear) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = CLEAR_VAL;
    end else if (pop) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = fifo_addr[rd_ptr];
      ram_wdata = fifo_data[rd_ptr];
    end
  end

  // Idle cycles keep the RAM address/data bus steady at the last driven values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      if (ram_en) begin
        hold_addr  <= ram_addr;
        hold_wdata <= ram_wdata;
      end
    end
  end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Randomised self-checking bench for tile_map_arbiter against a queue-based model of the arbiter
// and a model copy of the tile map.
module tb_tile_map_arbiter;

  localparam int            AW        = 11;
  localparam int            DW        = 8;
  localparam int            DEPTH     = 4;
  localparam int            TILES     = 1200;
  localparam logic [DW-1:0] CLEAR_VAL = 8'h00;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [2:0]    fifo_level;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef TILE_ARB_CLEAR_EN
  logic          clear_start = 1'b0;
  logic          clear_busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side RAM and the model's view of what it should contain.
  logic [DW-1:0] mem     [2048];
  logic [DW-1:0] ref_mem [2048];

  wr_t           wq[$];
  logic          rd_pend = 1'b0;
  logic [DW-1:0] rd_exp  = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wd   = '0;
  int            clr_mode = 0;   // 0 idle, 1 waiting for queue to empty, 2 clearing
  int            clr_next = 0;

  tile_map_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TILES(TILES), .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_level(fifo_level),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef TILE_ARB_CLEAR_EN
    , .clear_start(clear_start), .clear_busy(clear_busy)
`endif
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // One clock cycle: drive at the falling edge, compare 1 ns later, then advance the model.
  task automatic step(input logic req, input logic [AW-1:0] da, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input string tag,
                      input logic cs = 1'b0);
    logic          exp_ready, exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    int            lvl, mode0;
    @(negedge clk);
    disp_req = req; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd;
`ifdef TILE_ARB_CLEAR_EN
    clear_start = cs;
`endif
    #1;
    lvl       = wq.size();
    mode0     = clr_mode;
    exp_ready = (lvl < DEPTH) && (mode0 == 0);
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = last_addr; exp_wd = last_wd;
    if (req) begin
      exp_en = 1'b1; exp_addr = da;
    end else if (mode0 == 2) begin
      exp_en = 1'b1; exp_we = 1'b1; exp_addr = AW'(clr_next); exp_wd = CLEAR_VAL;
    end else if (lvl > 0) begin
      exp_en = 1'b1; exp_we = 1'b1; exp_addr = wq[0].addr; exp_wd = wq[0].data;
    end

    n_checks++;
    if (disp_valid !== rd_pend) begin
      n_fail++;
      $display("FAIL %s disp_valid: got %b, expected %b", tag, disp_valid, rd_pend);
    end
    if (rd_pend) begin
      n_checks++;
      if (disp_data !== rd_exp) begin
        n_fail++;
        $display("FAIL %s disp_data: got %h, expected %h", tag, disp_data, rd_exp);
      end
    end
    n_checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {exp_en, exp_we, exp_addr, exp_wd}) begin
      n_fail++;
      $display("FAIL %s ram bus: got en=%b we=%b addr=%0d wdata=%h, expected en=%b we=%b addr=%0d wdata=%h",
               tag, ram_en, ram_we, ram_addr, ram_wdata, exp_en, exp_we, exp_addr, exp_wd);
    end
    n_checks++;
    if (wr_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL %s wr_ready: got %b, expected %b", tag, wr_ready, exp_ready);
    end
    n_checks++;
    if (fifo_level !== 3'(lvl)) begin
      n_fail++;
      $display("FAIL %s fifo_level: got %0d, expected %0d", tag, fifo_level, lvl);
    end
`ifdef TILE_ARB_CLEAR_EN
    n_checks++;
    if (clear_busy !== (mode0 != 0)) begin
      n_fail++;
      $display("FAIL %s clear_busy: got %b, expected %b", tag, clear_busy, mode0 != 0);
    end
`endif

    rd_pend = req;
    rd_exp  = ref_mem[da];
    if (!req && mode0 == 2) begin
      ref_mem[clr_next] = CLEAR_VAL;
      clr_next++;
      if (clr_next == TILES) clr_mode = 0;
    end else if (!req && lvl > 0) begin
      ref_mem[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
    end
    if (exp_en) begin
      last_addr = exp_addr;
      last_wd   = exp_wd;
    end
    if (wv && exp_ready) wq.push_back('{addr: wa, data: wd});
`ifdef TILE_ARB_CLEAR_EN
    if (mode0 == 1 && lvl == 0) begin
      clr_mode = 2;
      clr_next = 0;
    end
    if (mode0 == 0 && cs) clr_mode = 1;
`endif
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, tag);
  endtask

  task automatic test_reset();
    #5;
    n_checks++;
    if ({wr_ready, ram_en, ram_we, disp_valid, fifo_level} !== 7'b0 ||
        ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b en=%b we=%b dv=%b lvl=%0d addr=%0d wd=%h, expected all zero",
               wr_ready, ram_en, ram_we, disp_valid, fifo_level, ram_addr, ram_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1 || ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got wr_ready=%b ram_en=%b, expected 1 and 0", wr_ready, ram_en);
    end
  endtask

  task automatic test_display_read();
    step(1'b1, 11'd5, 1'b0, '0, '0, "disp_read");
    step(1'b0, '0, 1'b0, '0, '0, "disp_read_result");
    n_checks++;
    if (disp_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL disp_read_value: got %h, expected 3c", disp_data);
    end
  endtask

  task automatic test_drain_order();
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, 1'b1, AW'(100 + i), DW'($urandom), "drain_push");
    idle(3, "drain_tail");
  endtask

  task automatic test_starve();
    for (int i = 0; i < 5; i++)
      step(1'b1, AW'($urandom_range(0, TILES - 1)), 1'b1, AW'(200 + i), DW'($urandom), "starve_push");
    idle(6, "starve_drain");
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, AW'($urandom_range(0, TILES - 1)), 1'b1, AW'(300 + i), DW'($urandom), "full_fill");
    step(1'b0, '0, 1'b1, 11'd400, 8'hA5, "full_pop_no_push");
    step(1'b0, '0, 1'b1, 11'd401, 8'h5A, "full_after_pop");
    idle(6, "full_drain");
  endtask

  task automatic test_reset_mid();
    step(1'b1, 11'd7, 1'b1, 11'd500, 8'h11, "rstmid_push");
    step(1'b1, 11'd8, 1'b1, 11'd501, 8'h22, "rstmid_push");
    @(negedge clk);
    disp_req = 1'b0; wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (fifo_level !== 3'd0 || ram_en !== 1'b0 || ram_we !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_assert: got lvl=%0d en=%b we=%b rdy=%b, expected 0 0 0 0",
               fifo_level, ram_en, ram_we, wr_ready);
    end
    wq.delete();
    rd_pend = 1'b0; last_addr = '0; last_wd = '0; clr_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_release: got en=%b lvl=%0d, expected 0 0", ram_en, fifo_level);
    end
    idle(3, "rstmid_after");
    n_checks++;
    if (mem[500] !== ref_mem[500] || mem[501] !== ref_mem[501]) begin
      n_fail++;
      $display("FAIL rstmid_discard: got mem500=%h mem501=%h, expected %h %h",
               mem[500], mem[501], ref_mem[500], ref_mem[501]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa;
      wa = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(TILES, 2047))
                                       : AW'($urandom_range(0, TILES - 1));
      step($urandom_range(0, 99) < 55, AW'($urandom_range(0, 2047)),
           $urandom_range(0, 1) == 1, wa, DW'($urandom), "random");
    end
    idle(DEPTH + 2, "random_drain");
  endtask

`ifdef TILE_ARB_CLEAR_EN
  task automatic test_clear();
    int cyc, nz;
    step(1'b1, 11'd3, 1'b1, 11'd900, 8'h77, "clear_queue");
    step(1'b0, '0, 1'b0, '0, '0, "clear_start", 1'b1);
    cyc = 0;
    while (clr_mode != 0 && cyc < 6000) begin
      step(cyc[0], AW'($urandom_range(0, TILES - 1)), 1'b1, 11'd10, 8'h99, "clear_run");
      cyc++;
    end
    n_checks++;
    if (clr_mode != 0) begin
      n_fail++;
      $display("FAIL clear_timeout: clear still active after %0d cycles, expected completion", cyc);
    end
    step(1'b0, '0, 1'b1, 11'd20, 8'h42, "clear_done");
    idle(2, "clear_done_drain");
    nz = 0;
    for (int a = 0; a < TILES; a++) if (a != 20 && mem[a] !== CLEAR_VAL) nz++;
    n_checks++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL clear_map: got %0d uncleared tiles, expected 0", nz);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5]     = 8'h3C;
    ref_mem[5] = 8'h3C;

    test_reset();
    test_display_read();
    test_drain_order();
    test_starve();
    test_full_pop();
    test_reset_mid();
    test_random();
`ifdef TILE_ARB_CLEAR_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
